// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sampling controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package trng_pkg;

   localparam int TRNG_WIDTH         = 8;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_FIFO_DEPTH     = 4;
   localparam int DEF_REPEAT_LIMIT   = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } trng_state_t;

endpackage

// File: rtl/trng_fifo.sv
// Small synchronous FIFO buffering random bytes for the consumer.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens the same cycle; pop ignored when empty.
module trng_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   // Reads as zero while empty so the output is clean straight out of reset.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/trng_sample_ctrl.sv
// Drives the SR-latch entropy network, health-checks raw bytes and buffers them for a consumer.
// Latency: SETTLE_CYCLES enable cycles + 1 capture cycle per raw byte; byte visible the cycle after capture.
// Backpressure: sampling pauses when the FIFO is full; define TRNG_VON_NEUMANN_EN to debias captured pairs.
module trng_sample_ctrl
   import trng_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
   parameter int REPEAT_LIMIT  = DEF_REPEAT_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   output logic                  rng_enable,
   input  logic [TRNG_WIDTH-1:0] rng_number,
   output logic [TRNG_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  stuck
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   trng_state_t           state;
   trng_state_t           state_nxt;
   logic [7:0]            settle_cnt;
   logic [7:0]            rep_cnt;
   logic [7:0]            rep_nxt;
   logic [TRNG_WIDTH-1:0] prev_cap;
   logic                  run_q;
   logic                  capture;
   logic                  stuck_hit;
   logic                  stuck_clr;

   logic                  fifo_push;
   logic [TRNG_WIDTH-1:0] fifo_push_data;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic [CW-1:0]         cnt_after;
   logic                  full_after;

   assign capture    = (state == ST_CAPTURE);
   assign rep_nxt    = ((rep_cnt != 8'd0) && (rng_number == prev_cap)) ? rep_cnt + 8'd1 : 8'd1;
   assign stuck_hit  = capture && (rep_nxt >= 8'(REPEAT_LIMIT));
   assign stuck_clr  = run_q & ~run;
   assign fifo_pop   = out_ready & ~fifo_empty;
   assign out_valid  = ~fifo_empty;
   // Occupancy once this cycle's push and pop land; decides whether another sample fits.
   assign cnt_after  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
   assign full_after = (cnt_after == CW'(FIFO_DEPTH));

`ifdef TRNG_VON_NEUMANN_EN
   logic                  half_vld;
   logic [TRNG_WIDTH-1:0] half_data;
   logic [6:0]            acc_bits;
   logic [2:0]            acc_cnt;
   logic [14:0]           vn_acc;
   logic [3:0]            vn_cnt;
   logic [3:0]            vn_lsb;
   logic                  vn_full;

   // Fold the current pair into the carried bits; oldest bit ends up most significant.
   always_comb begin
      vn_acc = {8'd0, acc_bits};
      vn_cnt = {1'b0, acc_cnt};
      for (int i = 0; i < TRNG_WIDTH; i++) begin
         if (half_data[i] != rng_number[i]) begin
            vn_acc = {vn_acc[13:0], half_data[i]};
            vn_cnt = vn_cnt + 4'd1;
         end
      end
      vn_full        = vn_cnt[3];
      vn_lsb         = vn_cnt - 4'd8;
      fifo_push      = capture && !stuck_hit && half_vld && vn_full;
      fifo_push_data = vn_full ? vn_acc[vn_lsb +: 8] : 8'd0;
   end

   // Pair tracking and leftover-bit carry; an abort drops only the unpaired half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_vld  <= 1'b0;
         half_data <= '0;
         acc_bits  <= '0;
         acc_cnt   <= '0;
      end else if (stuck_hit) begin
         half_vld <= 1'b0;
      end else if (capture) begin
         if (!half_vld) begin
            half_vld  <= 1'b1;
            half_data <= rng_number;
         end else begin
            half_vld <= 1'b0;
            acc_bits <= vn_acc[6:0];
            acc_cnt  <= vn_cnt[2:0];
         end
      end else if (!run) begin
         half_vld <= 1'b0;
      end
   end
`else
   // Raw mode: every healthy capture goes straight into the buffer.
   always_comb begin
      fifo_push      = capture && !stuck_hit;
      fifo_push_data = rng_number;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: start only with buffer space, abort on run drop, stop on health fault.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (run && !stuck && !fifo_full) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!run)                                          state_nxt = ST_IDLE;
            else if (settle_cnt == 8'(SETTLE_CYCLES - 1))      state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (!stuck_hit && run && !full_after) state_nxt = ST_SETTLE;
            else                                   state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from state: the latch network is enabled through settle and capture.
   always_comb begin
      rng_enable = (state == ST_SETTLE) || (state == ST_CAPTURE);
      busy       = (state != ST_IDLE);
   end

   // Settle counter restarts from zero on every entry into SETTLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  settle_cnt <= 8'd0;
      else if (state == ST_SETTLE) settle_cnt <= settle_cnt + 8'd1;
      else                         settle_cnt <= 8'd0;
   end

   // Repetition health check; the run falling edge is the only way out of a fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         stuck    <= 1'b0;
         rep_cnt  <= 8'd0;
         prev_cap <= '0;
      end else begin
         run_q <= run;
         if (stuck_hit)      stuck <= 1'b1;
         else if (stuck_clr) stuck <= 1'b0;
         if (capture) begin
            prev_cap <= rng_number;
            rep_cnt  <= stuck_hit ? 8'd0 : rep_nxt;
         end
      end
   end

   trng_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TRNG_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl with a scripted entropy source.
// Latency: n/a (testbench).
// Backpressure: consumer readiness is scripted per scenario.
module tb_trng_sample_ctrl;

   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic       rng_enable;
   logic [7:0] rng_number;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       stuck;

   always #5 clk = ~clk;

   trng_sample_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .FIFO_DEPTH    (4),
      .REPEAT_LIMIT  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .rng_enable (rng_enable),
      .rng_number (rng_number),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .stuck      (stuck)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] src_tab [8];
   int         src_len  = 1;
   int         src_base = 0;
   int         cap_cnt  = 0;
   int         push_full_viol = 0;
   logic [7:0] got [$];

   // Source byte advances once per completed capture.
   always_comb rng_number = src_tab[(cap_cnt - src_base) % src_len];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; out_ready = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_busy(input logic val, input string tag);
      int n = 0;
      while (busy !== val && n < 200) begin @(negedge clk); n++; end
      check(tag, busy, val);
   endtask

   task automatic wait_got(input int num, input string tag);
      int n = 0;
      while (got.size() < num && n < 400) begin @(negedge clk); n++; end
      check(tag, got.size(), num);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      run = 1'b0; out_ready = 1'b1;
      while (out_valid && n < 50) begin @(negedge clk); n++; end
      tick(1);
      check(tag, out_valid, 1'b0);
      out_ready = 1'b0;
   endtask

   task automatic set_src(input logic [7:0] first, input int len);
      for (int i = 0; i < 8; i++) src_tab[i] = first + 8'(i);
      src_len  = len;
      src_base = cap_cnt;
      got.delete();
   endtask

   // Observer: counts captures from the enable window, logs accepted bytes, watches push-on-full.
   initial begin : mon
      int en_run = 0;
      bit pend = 0;
      forever begin
         @(negedge clk); #2;
         if (pend) begin cap_cnt++; pend = 0; end
         if (rng_enable) begin
            en_run++;
            if (en_run == SETTLE + 1) begin pend = 1; en_run = 0; end
         end else begin
            en_run = 0;
         end
         if (out_valid && out_ready) got.push_back(out_data);
         if (dut.fifo_push && dut.fifo_full && !dut.fifo_pop) push_full_viol++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : main
      int en;
      int k;
      for (int i = 0; i < 8; i++) src_tab[i] = 8'h00;
      rst_n = 1'b0; run = 1'b0; out_ready = 1'b0;
      tick(2);
      check("rst_rng_enable", rng_enable, 1'b0);
      check("rst_busy",       busy,       1'b0);
      check("rst_stuck",      stuck,      1'b0);
      check("rst_out_valid",  out_valid,  1'b0);
      check("rst_out_data",   out_data,   8'h00);
      rst_n = 1'b1;
      tick(1);

      // Streaming 01,02,03 with a ready consumer.
      set_src(8'h01, 3);
      run = 1'b1; out_ready = 1'b1;
      en = 0; k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk); k++;
         if (!out_valid && rng_enable) en++;
      end
      check("a_first_valid",   out_valid, 1'b1);
      check("a_settle_cycles", en - 1, SETTLE);
      wait_got(3, "a_count");
      check("a_byte0", got[0], 8'h01);
      check("a_byte1", got[1], 8'h02);
      check("a_byte2", got[2], 8'h03);
      check("a_stuck", stuck, 1'b0);
      run = 1'b0;
      wait_busy(1'b0, "a_stop");

      // Consumer stalled: buffer fills, sampling halts, one pop buys one sample.
      do_reset();
      set_src(8'h10, 8);
      run = 1'b1;
      wait_busy(1'b1, "b_start");
      wait_busy(1'b0, "b_full_idle");
      tick(2);
      check("b_pushes",   cap_cnt - src_base, 4);
      check("b_busy",     busy,       1'b0);
      check("b_enable",   rng_enable, 1'b0);
      check("b_valid",    out_valid,  1'b1);
      check("b_head",     out_data,   8'h10);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      wait_busy(1'b1, "b_refill_start");
      wait_busy(1'b0, "b_refill_stop");
      tick(1);
      check("b_refill_enable", rng_enable, 1'b0);
      check("b_refill_pushes", cap_cnt - src_base, 5);
      drain("b_drained");
      check("b_total", got.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("b_data%0d", i), got[i], 8'h10 + 8'(i));

      // Pop lands in the capture cycle: push and pop together, sampling continues.
      do_reset();
      set_src(8'h20, 8);
      run = 1'b1;
      wait_busy(1'b1, "c_start");
      wait_busy(1'b0, "c_full_idle");
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      wait_busy(1'b1, "c_refill_start");
      tick(SETTLE);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("c_busy_after_pushpop",   busy,       1'b1);
      check("c_enable_after_pushpop", rng_enable, 1'b1);
      wait_busy(1'b0, "c_refull");
      drain("c_drained");
      check("c_total", got.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("c_data%0d", i), got[i], 8'h20 + 8'(i));

      // Stuck source: eighth identical capture trips the health check.
      do_reset();
      set_src(8'hA5, 1);
      run = 1'b1; out_ready = 1'b1;
      k = 0;
      while (!stuck && k < 200) begin @(negedge clk); k++; end
      check("d_stuck",   stuck,      1'b1);
      check("d_busy",    busy,       1'b0);
      check("d_enable",  rng_enable, 1'b0);
      tick(3);
      check("d_offered", got.size(), 7);
      check("d_last",    got[6],     8'hA5);
      check("d_held",    busy,       1'b0);
      run = 1'b0;
      tick(1);
      check("d_cleared", stuck, 1'b0);
      set_src(8'h01, 2);
      run = 1'b1;
      wait_got(2, "d_resume");
      check("d_resume0", got[0], 8'h01);
      check("d_resume1", got[1], 8'h02);
      check("d_resume_stuck", stuck, 1'b0);
      drain("d_drained");

      // Asynchronous reset mid-settle with three bytes buffered.
      do_reset();
      set_src(8'h30, 8);
      run = 1'b1;
      k = 0;
      while ((cap_cnt - src_base) < 3 && k < 100) begin @(negedge clk); k++; end
      check("e_buffered", cap_cnt - src_base, 3);
      check("e_in_settle", rng_enable, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("e_valid",  out_valid,  1'b0);
      check("e_enable", rng_enable, 1'b0);
      check("e_busy",   busy,       1'b0);
      check("e_data",   out_data,   8'h00);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      got.delete();
      wait_got(1, "e_resume");
      check("e_first_after_reset", got[0], 8'h33);
      drain("e_drained");

`ifdef TRNG_VON_NEUMANN_EN
      // Debias: (F0,0F) yields 0F, (AA,AA) yields nothing.
      do_reset();
      set_src(8'h00, 4);
      src_tab[0] = 8'hF0; src_tab[1] = 8'h0F; src_tab[2] = 8'hAA; src_tab[3] = 8'hAA;
      run = 1'b1; out_ready = 1'b1;
      k = 0;
      while ((cap_cnt - src_base) < 4 && k < 100) begin @(negedge clk); k++; end
      run = 1'b0;
      tick(3);
      check("f_vn_count", got.size(), 1);
      check("f_vn_byte",  got[0],     8'h0F);
`endif

      check("no_push_on_full", push_full_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
